pc_unit: RTL and testbench

Program-counter and fetch-sequencing stage that drives the 16-bit `pc` into the combinational instruction ROM/decoder. It consumes that stage's decoded `opcode`, `format` and `jmp_loc` outputs, plus the branch-condition result from the execute side, to select the next PC. It also owns the processor run/halt state and the start handshake.

---
 rtl/pc_unit.sv | 153 +++++++++++++++
 tb/tb_pc_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter and fetch sequencer with IDLE/RUN/HALT control and start handshake.
// Optional retired-instruction counter is built only when PC_RETIRE_COUNT_EN is defined.
module pc_unit #(
   parameter logic [15:0] RESET_PC = 16'd0,
   parameter logic [15:0] LAST_PC  = 16'd90
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stall,
   input  logic [3:0]  opcode,
   input  logic [1:0]  format,
   input  logic [15:0] jmp_loc,
   input  logic        branch_taken,
   output logic [15:0] pc,
   output logic        running,
   output logic        halted,
   output logic [15:0] retired
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   localparam logic [3:0] JMP_OP  = 4'b0010;
   localparam logic [3:0] HALT_OP = 4'b1110;
   localparam logic [3:0] BNE_OP  = 4'b1010;
   localparam logic [3:0] BEQ_OP  = 4'b1011;
   localparam logic [3:0] BLT_OP  = 4'b1100;
   localparam logic [3:0] BLS_OP  = 4'b1111;
   localparam logic [1:0] X_FORM  = 2'b11;

   state_t      state_r;
   state_t      state_s;
   logic [15:0] pc_r;
   logic [15:0] pc_s;
   logic        running_r;
   logic        halted_r;
   logic        is_branch_s;
   logic        halt_req_s;
   logic        redirect_s;

   // Classify the instruction currently presented by the decoder.
   always_comb begin
      is_branch_s = 1'b0;
      case (opcode)
         BNE_OP, BEQ_OP, BLT_OP, BLS_OP: is_branch_s = 1'b1;
         default:                        is_branch_s = 1'b0;
      endcase
      halt_req_s = (opcode == HALT_OP) || (format == X_FORM);
      redirect_s = (opcode == JMP_OP) || (is_branch_s && branch_taken);
   end

   // Next state and next PC; a stalled cycle leaves everything as is.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      case (state_r)
         ST_IDLE: begin
            if (start && !stall) begin
               state_s = ST_RUN;
               pc_s    = RESET_PC;
            end else begin
               state_s = ST_IDLE;
               pc_s    = pc_r;
            end
         end
         ST_RUN: begin
            if (stall) begin
               state_s = ST_RUN;
               pc_s    = pc_r;
            end else if (halt_req_s) begin
               state_s = ST_HALT;
               pc_s    = pc_r;
            end else if (redirect_s) begin
               // A target equal to pc is a legal self-loop, not a halt.
               state_s = ST_RUN;
               pc_s    = jmp_loc;
            end else if (pc_r == LAST_PC) begin
               state_s = ST_HALT;
               pc_s    = pc_r;
            end else begin
               state_s = ST_RUN;
               pc_s    = pc_r + 16'd1;
            end
         end
         ST_HALT: begin
            if (start && !stall) begin
               state_s = ST_RUN;
               pc_s    = RESET_PC;
            end else begin
               state_s = ST_HALT;
               pc_s    = pc_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            pc_s    = RESET_PC;
         end
      endcase
   end

   // State, PC and status flags; flags decode the next state so they move with it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         pc_r      <= RESET_PC;
         running_r <= 1'b0;
         halted_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         running_r <= (state_s == ST_RUN);
         halted_r  <= (state_s == ST_HALT);
      end
   end

   assign pc      = pc_r;
   assign running = running_r;
   assign halted  = halted_r;

`ifdef PC_RETIRE_COUNT_EN
   logic [15:0] retired_r;
   logic        retire_s;
   logic        clear_s;

   // Retire and restart qualifiers for the counter.
   always_comb begin
      retire_s = (state_r == ST_RUN) && !stall;
      clear_s  = (state_r == ST_HALT) && start && !stall;
   end

   // Saturating retired-instruction counter, cleared on restart from HALT.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         retired_r <= 16'd0;
      end else if (clear_s) begin
         retired_r <= 16'd0;
      end else if (retire_s && (retired_r != 16'hFFFF)) begin
         retired_r <= retired_r + 16'd1;
      end else begin
         retired_r <= retired_r;
      end
   end

   assign retired = retired_r;
`else
   assign retired = 16'd0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: two instances (LAST_PC=5 and LAST_PC=0xFFFE) share stimulus;
// retired expectations follow PC_RETIRE_COUNT_EN.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic [3:0]  opcode = 4'b0100;
   logic [1:0]  format = 2'b00;
   logic [15:0] jmp_loc = 16'd0;
   logic        branch_taken = 1'b0;
   logic [15:0] pc_a, pc_b, retired_a, retired_b;
   logic        running_a, running_b, halted_a, halted_b;

   always #5 clk = ~clk;

   pc_unit #(.RESET_PC(16'd0), .LAST_PC(16'd5)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .opcode(opcode),
      .format(format), .jmp_loc(jmp_loc), .branch_taken(branch_taken),
      .pc(pc_a), .running(running_a), .halted(halted_a), .retired(retired_a));

   pc_unit #(.RESET_PC(16'd0), .LAST_PC(16'hFFFE)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .opcode(opcode),
      .format(format), .jmp_loc(jmp_loc), .branch_taken(branch_taken),
      .pc(pc_b), .running(running_b), .halted(halted_b), .retired(retired_b));

   typedef struct packed {
      logic [15:0] pc;
      logic        running;
      logic        halted;
      logic [15:0] retired;
   } obs_t;

   typedef struct {
      logic        rn;
      logic        st;
      logic        sl;
      logic [3:0]  opc;
      logic [1:0]  fmt;
      logic [15:0] jl;
      logic        bt;
      obs_t        exp;
   } vec_t;

   localparam logic [3:0] LIM  = 4'b0100;
   localparam logic [3:0] JMP  = 4'b0010;
   localparam logic [3:0] HLT  = 4'b1110;
   localparam logic [3:0] BNE  = 4'b1010;
   localparam logic [3:0] BEQ  = 4'b1011;
   localparam logic [3:0] BLT  = 4'b1100;
   localparam logic [3:0] BLS  = 4'b1111;
`ifdef PC_RETIRE_COUNT_EN
   localparam logic [15:0] RET_MASK = 16'hFFFF;
`else
   localparam logic [15:0] RET_MASK = 16'h0000;
`endif

   vec_t plan[$];
   obs_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic void add(input logic rn, input logic st, input logic sl, input logic [3:0] opc,
                               input logic [1:0] fmt, input logic [15:0] jl, input logic bt,
                               input logic [15:0] epc, input logic erun, input logic ehalt, input int eret);
      vec_t v;
      v.rn = rn; v.st = st; v.sl = sl; v.opc = opc; v.fmt = fmt; v.jl = jl; v.bt = bt;
      v.exp.pc = epc; v.exp.running = erun; v.exp.halted = ehalt;
      v.exp.retired = 16'(eret) & RET_MASK;
      plan.push_back(v);
   endfunction

   // One non-stalled RUN instruction that stays in RUN.
   function automatic void add_run(input logic [3:0] opc, input logic [15:0] jl, input logic bt,
                                   input logic [15:0] epc, input int eret);
      add(1'b1, 1'b0, 1'b0, opc, 2'b00, jl, bt, epc, 1'b1, 1'b0, eret);
   endfunction

   // Two reset cycles then start: RUN at pc 0 with nothing retired.
   function automatic void add_boot();
      add(1'b0, 1'b0, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 0);
      add(1'b0, 1'b0, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 0);
      add(1'b1, 1'b1, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b1, 1'b0, 0);
   endfunction

   task automatic drive(input vec_t v);
      reset_n = v.rn; start = v.st; stall = v.sl; opcode = v.opc;
      format = v.fmt; jmp_loc = v.jl; branch_taken = v.bt;
   endtask

   task automatic test_reset();
      obs_t got_a, got_b, exp;
      plan.delete();
      add(1'b0, 1'b0, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 0);
      add(1'b0, 1'b1, 1'b1, BEQ, 2'b00, 16'd7, 1'b1, 16'd0, 1'b0, 1'b0, 0);
      add(1'b1, 1'b0, 1'b0, JMP, 2'b00, 16'd9, 1'b0, 16'd0, 1'b0, 1'b0, 0);
      add(1'b1, 1'b0, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 0);
      foreach (plan[i]) begin
         drive(plan[i]);
         sb.push_back(plan[i].exp);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got_a = {pc_a, running_a, halted_a, retired_a};
         got_b = {pc_b, running_b, halted_b, retired_b};
         vectors += 2;
         if (got_a !== exp) begin
            miscompares++;
            $display("FAIL reset_a[%0d]: got pc=%h run=%b halt=%b ret=%0d, expected pc=%h run=%b halt=%b ret=%0d",
                     i, got_a.pc, got_a.running, got_a.halted, got_a.retired, exp.pc, exp.running, exp.halted, exp.retired);
         end
         if (got_b !== exp) begin
            miscompares++;
            $display("FAIL reset_b[%0d]: got pc=%h run=%b halt=%b ret=%0d, expected pc=%h run=%b halt=%b ret=%0d",
                     i, got_b.pc, got_b.running, got_b.halted, got_b.retired, exp.pc, exp.running, exp.halted, exp.retired);
         end
      end
   endtask

   task automatic test_straight_line();
      obs_t got, exp;
      plan.delete();
      add_boot();
      for (int k = 1; k <= 5; k++) add_run(LIM, 16'd0, 1'b0, 16'(k), k);
      add(1'b1, 1'b0, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd5, 1'b0, 1'b1, 6);
      add(1'b1, 1'b0, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd5, 1'b0, 1'b1, 6);
      foreach (plan[i]) begin
         drive(plan[i]);
         sb.push_back(plan[i].exp);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {pc_a, running_a, halted_a, retired_a};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL straight[%0d]: got pc=%h run=%b halt=%b ret=%0d, expected pc=%h run=%b halt=%b ret=%0d",
                     i, got.pc, got.running, got.halted, got.retired, exp.pc, exp.running, exp.halted, exp.retired);
         end
      end
   endtask

   task automatic test_branch();
      obs_t got, exp;
      plan.delete();
      add_boot();
      add_run(JMP, 16'd17,  1'b0, 16'd17,  1);
      add_run(BEQ, 16'd46,  1'b1, 16'd46,  2);
      add_run(JMP, 16'd17,  1'b0, 16'd17,  3);
      add_run(BEQ, 16'd46,  1'b0, 16'd18,  4);
      add_run(LIM, 16'd99,  1'b1, 16'd19,  5);
      add_run(BNE, 16'd100, 1'b1, 16'd100, 6);
      add_run(BLT, 16'd200, 1'b1, 16'd200, 7);
      add_run(BLS, 16'd200, 1'b1, 16'd200, 8);
      add_run(BLS, 16'd300, 1'b0, 16'd201, 9);
      add(1'b1, 1'b0, 1'b0, LIM, 2'b11, 16'd50, 1'b0, 16'd201, 1'b0, 1'b1, 10);
      foreach (plan[i]) begin
         drive(plan[i]);
         sb.push_back(plan[i].exp);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {pc_b, running_b, halted_b, retired_b};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL branch[%0d]: got pc=%h run=%b halt=%b ret=%0d, expected pc=%h run=%b halt=%b ret=%0d",
                     i, got.pc, got.running, got.halted, got.retired, exp.pc, exp.running, exp.halted, exp.retired);
         end
      end
   endtask

   task automatic test_jump_wrap();
      obs_t got, exp;
      plan.delete();
      add_boot();
      add_run(LIM, 16'd0, 1'b0, 16'd1, 1);
      add_run(LIM, 16'd0, 1'b0, 16'd2, 2);
      add_run(LIM, 16'd0, 1'b0, 16'd3, 3);
      add_run(JMP, 16'hFFFF, 1'b0, 16'hFFFF, 4);
      add_run(LIM, 16'd0, 1'b0, 16'h0000, 5);
      add_run(LIM, 16'd0, 1'b0, 16'h0001, 6);
      add_run(JMP, 16'hFFFE, 1'b0, 16'hFFFE, 7);
      add(1'b1, 1'b0, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'hFFFE, 1'b0, 1'b1, 8);
      foreach (plan[i]) begin
         drive(plan[i]);
         sb.push_back(plan[i].exp);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {pc_b, running_b, halted_b, retired_b};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL wrap[%0d]: got pc=%h run=%b halt=%b ret=%0d, expected pc=%h run=%b halt=%b ret=%0d",
                     i, got.pc, got.running, got.halted, got.retired, exp.pc, exp.running, exp.halted, exp.retired);
         end
      end
   endtask

   task automatic test_stall();
      obs_t got, exp;
      plan.delete();
      add(1'b0, 1'b0, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 0);
      add(1'b1, 1'b1, 1'b1, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 0);
      add(1'b1, 1'b1, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b1, 1'b0, 0);
      add_run(JMP, 16'd8, 1'b0, 16'd8, 1);
      for (int k = 0; k < 3; k++)
         add(1'b1, 1'b0, 1'b1, BEQ, 2'b00, 16'd40, 1'b1, 16'd8, 1'b1, 1'b0, 1);
      add_run(BEQ, 16'd40, 1'b1, 16'd40, 2);
      add(1'b1, 1'b1, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd41, 1'b1, 1'b0, 3);
      foreach (plan[i]) begin
         drive(plan[i]);
         sb.push_back(plan[i].exp);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {pc_b, running_b, halted_b, retired_b};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL stall[%0d]: got pc=%h run=%b halt=%b ret=%0d, expected pc=%h run=%b halt=%b ret=%0d",
                     i, got.pc, got.running, got.halted, got.retired, exp.pc, exp.running, exp.halted, exp.retired);
         end
      end
   endtask

   task automatic test_halt_restart();
      obs_t got, exp;
      plan.delete();
      add_boot();
      add_run(JMP, 16'd12, 1'b0, 16'd12, 1);
      add(1'b1, 1'b0, 1'b0, HLT, 2'b00, 16'd99, 1'b1, 16'd12, 1'b0, 1'b1, 2);
      add(1'b1, 1'b0, 1'b0, LIM, 2'b00, 16'd0,  1'b0, 16'd12, 1'b0, 1'b1, 2);
      add(1'b1, 1'b1, 1'b1, LIM, 2'b00, 16'd0,  1'b0, 16'd12, 1'b0, 1'b1, 2);
      add(1'b1, 1'b1, 1'b0, LIM, 2'b00, 16'd0,  1'b0, 16'd0,  1'b1, 1'b0, 0);
      add_run(LIM, 16'd0, 1'b0, 16'd1, 1);
      foreach (plan[i]) begin
         drive(plan[i]);
         sb.push_back(plan[i].exp);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {pc_b, running_b, halted_b, retired_b};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL halt_restart[%0d]: got pc=%h run=%b halt=%b ret=%0d, expected pc=%h run=%b halt=%b ret=%0d",
                     i, got.pc, got.running, got.halted, got.retired, exp.pc, exp.running, exp.halted, exp.retired);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      obs_t got, exp;
      plan.delete();
      add_boot();
      add_run(JMP, 16'd30, 1'b0, 16'd30, 1);
      add(1'b0, 1'b0, 1'b1, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 0);
      add(1'b1, 1'b0, 1'b0, LIM, 2'b00, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 0);
      foreach (plan[i]) begin
         drive(plan[i]);
         sb.push_back(plan[i].exp);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {pc_b, running_b, halted_b, retired_b};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_mid[%0d]: got pc=%h run=%b halt=%b ret=%0d, expected pc=%h run=%b halt=%b ret=%0d",
                     i, got.pc, got.running, got.halted, got.retired, exp.pc, exp.running, exp.halted, exp.retired);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_straight_line();
      test_branch();
      test_jump_wrap();
      test_stall();
      test_halt_restart();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
